// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, types and helpers for the conv block.
//   WORD_LENGTH / IMAGE_SIZE / KERNEL_SIZE / OUT_SIZE / ACC_LENGTH and the
//   bus widths derived from them; out_index() maps an accepted pixel
//   position (bottom-right corner of a full window) to its data_out slot.
package conv_pkg;

    localparam int unsigned WORD_LENGTH   = 8;
    localparam int unsigned IMAGE_SIZE    = 28;
    localparam int unsigned KERNEL_SIZE   = 5;
    localparam int unsigned OUT_SIZE      = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam int unsigned ACC_LENGTH    = 16;

    localparam int unsigned KERNEL_TAPS   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned WEIGHT_BITS   = KERNEL_TAPS * WORD_LENGTH;
    localparam int unsigned OUT_PIXELS    = OUT_SIZE * OUT_SIZE;
    localparam int unsigned DATA_OUT_BITS = OUT_PIXELS * ACC_LENGTH;
    localparam int unsigned LB_ROWS       = KERNEL_SIZE - 1;
    localparam int unsigned POS_BITS      = $clog2(IMAGE_SIZE);
    localparam int unsigned IDX_BITS      = $clog2(OUT_PIXELS);

    typedef logic signed [WORD_LENGTH-1:0] pixel_t;
    typedef logic [ACC_LENGTH-1:0]         acc_t;

    // Output slot for the window whose newest pixel sits at (row, col).
    function automatic logic [IDX_BITS-1:0] out_index(input logic [POS_BITS-1:0] row,
                                                      input logic [POS_BITS-1:0] col);
        logic [IDX_BITS-1:0] r;
        logic [IDX_BITS-1:0] c;
        r = IDX_BITS'(row - POS_BITS'(KERNEL_SIZE - 1));
        c = IDX_BITS'(col - POS_BITS'(KERNEL_SIZE - 1));
        return r * IDX_BITS'(OUT_SIZE) + c;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// conv_mac: 25-tap signed dot product with one register stage.
//   clk, rst     : clock, asynchronous active-low reset
//   in_valid     : window/weights form a result to compute this cycle
//   window       : 25 signed 8-bit pixels, tap i at [8i+7:8i]
//   weights      : 25 signed 8-bit weights, same packing
//   sum          : registered sum of products, wrapped to 16 bits
//   out_valid    : sum is valid (one cycle after in_valid)
module conv_mac
    import conv_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WEIGHT_BITS-1:0] window,
    input  logic [WEIGHT_BITS-1:0] weights,
    output logic [ACC_LENGTH-1:0]  sum,
    output logic                   out_valid
);

    acc_t   acc_d;
    acc_t   sum_q;
    logic   valid_q;
    pixel_t tap_p;
    pixel_t tap_w;
    logic signed [ACC_LENGTH-1:0] ext_p;
    logic signed [ACC_LENGTH-1:0] ext_w;

    // Operands are sign-extended to the accumulator width first; the low
    // 16 bits of a 16x16 product equal those of the true 8x8 product.
    always_comb begin
        acc_d = '0;
        tap_p = '0;
        tap_w = '0;
        ext_p = '0;
        ext_w = '0;
        for (int i = 0; i < KERNEL_TAPS; i++) begin
            tap_p = window[i*WORD_LENGTH +: WORD_LENGTH];
            tap_w = weights[i*WORD_LENGTH +: WORD_LENGTH];
            ext_p = tap_p;
            ext_w = tap_w;
            acc_d = acc_d + acc_t'(ext_p * ext_w);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= acc_d;
            valid_q <= in_valid;
        end
    end

    assign sum       = sum_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/conv.sv
// conv: streaming 28x28 * 5x5 valid correlation producing a 24x24 frame.
//   clk, rst      : clock, asynchronous active-low reset
//   in_valid      : data_in carries a pixel (raster order)
//   data_in       : signed 8-bit pixel
//   weight_value  : 25 signed 8-bit weights, (kr,kc) at [8i+7:8i], i = kr*5+kc
//   data_out      : 576 signed 16-bit results, (r,c) at [16w+15:16w], w = r*24+c
//   out_valid     : data_out holds the complete frame; stays high until reset
// Pipeline: accept edge updates line buffer/window, +1 edge registers the MAC
// sum, +2 edge writes the result slot (and raises out_valid for the last one).
module conv
    import conv_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WORD_LENGTH-1:0]   data_in,
    input  logic [WEIGHT_BITS-1:0]   weight_value,
    output logic [DATA_OUT_BITS-1:0] data_out,
    output logic                     out_valid
);

    localparam logic [POS_BITS-1:0] LAST_POS = POS_BITS'(IMAGE_SIZE - 1);
    localparam logic [POS_BITS-1:0] FIRST_FULL = POS_BITS'(KERNEL_SIZE - 1);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(OUT_PIXELS - 1);
    localparam int unsigned NEWEST = KERNEL_SIZE - 1;

    logic [POS_BITS-1:0] row_q;
    logic [POS_BITS-1:0] col_q;
    logic                done_q;
    logic                accept;

    pixel_t lb_q  [LB_ROWS][IMAGE_SIZE];
    pixel_t win_q [KERNEL_SIZE][KERNEL_SIZE];

    logic                   win_valid_q;
    logic [IDX_BITS-1:0]    win_idx_q;
    logic [IDX_BITS-1:0]    mac_idx_q;
    logic [WEIGHT_BITS-1:0] window;
    acc_t                   mac_sum;
    logic                   mac_valid;

    acc_t res_q [OUT_PIXELS];
    logic out_valid_q;

    // Once the last pixel is in, further input is dropped.
    assign accept = in_valid & ~done_q;

    // Raster position of the next pixel to accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q  <= '0;
            col_q  <= '0;
            done_q <= 1'b0;
        end else if (accept) begin
            if (col_q == LAST_POS) begin
                col_q <= '0;
                if (row_q == LAST_POS) begin
                    done_q <= 1'b1;
                end else begin
                    row_q <= row_q + 1'b1;
                end
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Line buffer holds the previous 4 rows column-wise: lb_q[0] is oldest.
    // The window shifts left and takes the column {lb rows, new pixel}.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < LB_ROWS; j++) begin
                for (int c = 0; c < IMAGE_SIZE; c++) begin
                    lb_q[j][c] <= '0;
                end
            end
            for (int kr = 0; kr < KERNEL_SIZE; kr++) begin
                for (int kc = 0; kc < KERNEL_SIZE; kc++) begin
                    win_q[kr][kc] <= '0;
                end
            end
        end else if (accept) begin
            for (int j = 0; j < LB_ROWS - 1; j++) begin
                lb_q[j][col_q] <= lb_q[j+1][col_q];
            end
            lb_q[LB_ROWS-1][col_q] <= data_in;
            for (int kr = 0; kr < KERNEL_SIZE; kr++) begin
                for (int kc = 0; kc < KERNEL_SIZE - 1; kc++) begin
                    win_q[kr][kc] <= win_q[kr][kc+1];
                end
            end
            for (int j = 0; j < LB_ROWS; j++) begin
                win_q[j][NEWEST] <= lb_q[j][col_q];
            end
            win_q[NEWEST][NEWEST] <= data_in;
        end
    end

    always_comb begin
        window = '0;
        for (int kr = 0; kr < KERNEL_SIZE; kr++) begin
            for (int kc = 0; kc < KERNEL_SIZE; kc++) begin
                window[(kr*KERNEL_SIZE+kc)*WORD_LENGTH +: WORD_LENGTH] = win_q[kr][kc];
            end
        end
    end

    // Window is complete only when the accepted pixel is at row>=4, col>=4.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_valid_q <= 1'b0;
            win_idx_q   <= '0;
            mac_idx_q   <= '0;
        end else begin
            win_valid_q <= accept && (row_q >= FIRST_FULL) && (col_q >= FIRST_FULL);
            if (accept) begin
                win_idx_q <= out_index(row_q, col_q);
            end
            mac_idx_q <= win_idx_q;
        end
    end

    conv_mac u_mac (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (win_valid_q),
        .window    (window),
        .weights   (weight_value),
        .sum       (mac_sum),
        .out_valid (mac_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < OUT_PIXELS; w++) begin
                res_q[w] <= '0;
            end
            out_valid_q <= 1'b0;
        end else if (mac_valid) begin
            res_q[mac_idx_q] <= mac_sum;
            if (mac_idx_q == LAST_IDX) begin
                out_valid_q <= 1'b1;
            end
        end
    end

    always_comb begin
        data_out = '0;
        for (int w = 0; w < OUT_PIXELS; w++) begin
            data_out[w*ACC_LENGTH +: ACC_LENGTH] = res_q[w];
        end
    end

    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_conv.sv
// tb_conv: frame-level scoreboard bench for conv. Each frame's expected
// 576 results come from a direct integer correlation model, are queued
// before the pixels are driven, and are popped once out_valid rises.
module tb_conv;
    import conv_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     in_valid = 1'b0;
    logic [WORD_LENGTH-1:0]   data_in = '0;
    logic [WEIGHT_BITS-1:0]   weight_value = '0;
    logic [DATA_OUT_BITS-1:0] data_out;
    logic                     out_valid;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] sb_q[$];
    int pix[784];
    int wts[25];

    always #5 clk = ~clk;

    conv dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .data_in      (data_in),
        .weight_value (weight_value),
        .data_out     (data_out),
        .out_valid    (out_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_weights();
        for (int i = 0; i < 25; i++) weight_value[8*i +: 8] = 8'(wts[i]);
    endtask

    task automatic push_model();
        int s;
        for (int r = 0; r < 24; r++) begin
            for (int c = 0; c < 24; c++) begin
                s = 0;
                for (int kr = 0; kr < 5; kr++)
                    for (int kc = 0; kc < 5; kc++)
                        s += pix[(r+kr)*28 + c + kc] * wts[kr*5 + kc];
                sb_q.push_back(16'(s));
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(|data_out), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_valid", 32'(out_valid), 0);
        check("idle_data", 32'(|data_out), 0);
    endtask

    task automatic drive(input int first, input int last, input bit gaps, output bit early);
        early = 1'b0;
        for (int k = first; k <= last; k++) begin
            @(negedge clk);
            if (out_valid) early = 1'b1;
            in_valid = 1'b1;
            data_in  = 8'(pix[k]);
            if (gaps && (k % 10 == 9)) begin
                repeat (3) begin
                    @(negedge clk);
                    if (out_valid) early = 1'b1;
                    in_valid = 1'b0;
                    data_in  = 8'($urandom);
                end
            end
        end
    endtask

    task automatic compare_all(input string name);
        logic [15:0] e;
        for (int w = 0; w < 576; w++) begin
            e = (sb_q.size() != 0) ? sb_q.pop_front() : 16'hxxxx;
            check($sformatf("%s[%0d]", name, w), 32'(data_out[w*16 +: 16]), 32'(e));
        end
    endtask

    task automatic run_frame(input string name, input bit gaps);
        bit early;
        int n;
        load_weights();
        push_model();
        apply_reset();
        drive(0, 783, gaps, early);
        check({name, "_early"}, 32'(early), 0);
        // Negedge after the accepting edge counts 1; out_valid due on the 3rd.
        n = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            n++;
        end while (!out_valid && n < 20);
        check({name, "_latency"}, n, 3);
        compare_all(name);
        // Trailing pixels must not disturb the frozen frame.
        repeat (40) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(1));
            data_in  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_hold_valid"}, 32'(out_valid), 1);
        push_model();
        compare_all({name, "_hold"});
    endtask

    initial begin
        bit early;

        // All-zero weights, random pixels.
        for (int k = 0; k < 784; k++) pix[k] = int'($urandom_range(255)) - 128;
        for (int i = 0; i < 25; i++) wts[i] = 0;
        run_frame("zero_w", 1'b0);

        // Centre tap only: output is the shifted input pattern.
        for (int k = 0; k < 784; k++) pix[k] = (k % 256 >= 128) ? (k % 256) - 256 : k % 256;
        for (int i = 0; i < 25; i++) wts[i] = (i == 12) ? 1 : 0;
        run_frame("centre", 1'b0);

        // All ones.
        for (int k = 0; k < 784; k++) pix[k] = 1;
        for (int i = 0; i < 25; i++) wts[i] = 1;
        run_frame("ones", 1'b0);

        // Positive and negative extremes, exercising wrap.
        for (int k = 0; k < 784; k++) pix[k] = 127;
        for (int i = 0; i < 25; i++) wts[i] = 127;
        run_frame("max", 1'b0);
        for (int k = 0; k < 784; k++) pix[k] = -128;
        for (int i = 0; i < 25; i++) wts[i] = -128;
        run_frame("min", 1'b0);

        // Random frame, contiguous and with input gaps.
        for (int k = 0; k < 784; k++) pix[k] = int'($urandom_range(255)) - 128;
        for (int i = 0; i < 25; i++) wts[i] = int'($urandom_range(255)) - 128;
        run_frame("rand", 1'b0);
        run_frame("rand_gaps", 1'b1);

        // Abandon a frame after pixel 400, then a fresh all-ones frame.
        for (int k = 0; k < 784; k++) pix[k] = int'($urandom_range(255)) - 128;
        for (int i = 0; i < 25; i++) wts[i] = int'($urandom_range(255)) - 128;
        load_weights();
        apply_reset();
        drive(0, 400, 1'b0, early);
        @(negedge clk);
        in_valid = 1'b0;
        check("partial_early", 32'(early | out_valid), 0);
        for (int k = 0; k < 784; k++) pix[k] = 1;
        for (int i = 0; i < 25; i++) wts[i] = 1;
        run_frame("after_abort", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv.md
CONV -- requirements
Module: conv

Interface
REQ-001 Parameters: WORD_LENGTH = 8 (pixel/weight bits); IMAGE_SIZE = 28 (square input side); KERNEL_SIZE = 5 (square kernel side); OUT_SIZE = IMAGE_SIZE-KERNEL_SIZE+1 = 24 (derived); ACC_LENGTH = 16 (result bits).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low (asserted when 0).
REQ-004 in_valid  input  1  data_in carries a valid pixel this cycle.
REQ-005 data_in  input  8  signed two's-complement pixel, raster order (row-major, pixel index k = row*28+col).
REQ-006 weight_value  input  200  25 signed 8-bit weights, static for the frame; weight (kr,kc) at bits [8i+7:8i], i = kr*5+kc.
REQ-007 data_out  output  9216  576 signed 16-bit results; output (r,c) at bits [16w+15:16w], w = r*24+c.
REQ-008 out_valid  output  1  high when data_out holds the complete frame.

Function
REQ-009 Result SHALL be out(r,c) = sum over kr,kc in 0..4 of pixel(r+kr, c+kc) * weight(kr,kc); correlation, no kernel flip, no bias, valid padding, stride 1.
REQ-010 Products SHALL be signed 8x8 -> 16 bits; accumulation SHALL be modulo 2^16 (wrap, no saturation).
REQ-011 A pixel SHALL be accepted on each rising edge where in_valid = 1; cycles with in_valid = 0 SHALL be ignored (no gap sensitivity).
REQ-012 The block SHALL count accepted pixels 0..783; the first accepted pixel after reset is pixel index 0.
REQ-013 Output (r,c) SHALL be computed once pixel (r+4, c+4) is accepted, via a 4-row line buffer plus 5x5 sliding window, and stored into its data_out slot.
REQ-014 out_valid SHALL rise exactly 2 clock edges after the edge accepting pixel 783 and then stay high with data_out frozen until reset.
REQ-015 out_valid SHALL rise exactly once per frame; no glitch or toggle while frame data is incomplete.
REQ-016 Pixels presented after pixel 783 (in_valid high or low) SHALL be ignored; data_out SHALL not change.
REQ-017 weight_value SHALL be sampled combinationally at each MAC; changing weights mid-frame is unsupported (result undefined).

Reset
REQ-018 While rst = 0: data_out = 0, out_valid = 0, pixel counter = 0, line buffer and window cleared, asynchronously.
REQ-019 Reset asserted mid-frame SHALL abandon the frame; the first accepted pixel after release is pixel index 0 of a new frame.
REQ-020 No output change SHALL occur between reset release and the first accepted pixel.

Structure
REQ-021 Package conv_pkg SHALL hold WORD_LENGTH, IMAGE_SIZE, KERNEL_SIZE, OUT_SIZE, ACC_LENGTH and derived bus widths.
REQ-022 One sub-module conv_mac SHALL implement the 25-tap signed dot product (25 x 8-bit window, 25 x 8-bit weights -> 16-bit wrapped sum), registered once.
REQ-023 Top-level conv SHALL contain the pixel counter, row/column tracking, line buffer, window, output register bank and out_valid logic.

Verification
REQ-024 All weights 0, arbitrary pixels -> every output 0x0000; out_valid rises once, 2 edges after pixel 783.
REQ-025 Weight index 12 = 1, others 0, pixel k = k mod 256 as signed -> out(r,c) = sign-extended pixel((r+2)*28+c+2).
REQ-026 All pixels 1, all weights 1 -> all 576 outputs = 25 (0x0019).
REQ-027 All pixels 127, weights 127 -> all outputs 10009 (403225 mod 65536); all pixels -128, weights -128 -> all outputs 16384.
REQ-028 in_valid dropped for 3 cycles every 10 pixels -> results identical to the contiguous-stream run.
REQ-029 Reset pulsed after pixel 400, then a full frame of all-1 pixels/weights -> out_valid stays 0 until 2 edges after the new pixel 783, all outputs 25.
